// File: rtl/div_sequencer_if.sv
// div_sequencer_if
//   Command/result bundle between the main control unit (master) and the
//   HI/LO division sequencer (slave).
//
//   Handshake: the master raises start for one cycle with is_signed,
//   dividend and divisor stable. The slave accepts it only while busy is
//   low; a start seen while busy is high is dropped, not queued. The
//   result is announced by a single-cycle done pulse, with div_zero
//   qualifying it. hi/lo are architectural registers and can be read at
//   any time. hi_we/lo_we (MTHI/MTLO) take effect only while idle and
//   without a simultaneous start.
//
//   dbg_state mirrors the internal FSM state (0 IDLE, 1 ITER, 2 FIXUP,
//   3 DONE) for observation.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, is_signed, dividend, divisor, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo, dbg_state
  );

  modport slave (
    input  start, is_signed, dividend, divisor, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo, dbg_state
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
//   Multi-cycle restoring divider that owns the HI (remainder) and LO
//   (quotient) registers. It performs one quotient bit per cycle over
//   WIDTH cycles, then applies the MIPS sign fix-up. The quotient
//   truncates toward zero, and the remainder takes the sign of the
//   dividend. A zero divisor skips the loop and reports div_zero. In
//   that case HI/LO are left untouched.
//
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; clears everything, aborts a divide
//   bus    : div_sequencer_if.slave
//            in : start, is_signed, dividend, divisor, hi_we, lo_we, wdata
//            out: busy, done, div_zero, hi, lo, dbg_state
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  div_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_count;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_zero_flag;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Operand magnitudes. Negating the most negative value yields the same
  // bit pattern, which is its correct unsigned magnitude.
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;

  assign w_a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_a_neg ? -bus.dividend : bus.dividend;
  assign w_dvs_mag = w_b_neg ? -bus.divisor  : bus.divisor;

  // One restoring step: shift {rem, quo} left and try to subtract.
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_fix;
  logic [WIDTH-1:0] w_lo_fix;

  assign w_rem_sh = (r_rem << 1) | {{WIDTH{1'b0}}, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs_mag});
  assign w_lo_fix = r_q_neg ? -r_quo : r_quo;
  assign w_hi_fix = r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dvs_mag   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_count     <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_zero_flag <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            // start takes priority over a same-cycle MTHI/MTLO.
            r_dvs_mag <= w_dvs_mag;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
            if (bus.divisor == '0) begin
              r_zero_flag <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_zero_flag <= 1'b0;
              r_rem       <= '0;
              r_quo       <= w_dvd_mag;
              r_count     <= '0;
              r_state     <= S_ITER;
            end
          end else begin
            if (bus.hi_we) r_hi <= bus.wdata;
            if (bus.lo_we) r_lo <= bus.wdata;
          end
        end
        S_ITER: begin
          r_rem   <= w_ge ? (w_rem_sh - {1'b0, r_dvs_mag}) : w_rem_sh;
          r_quo   <= {r_quo[WIDTH-2:0], w_ge};
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_lo    <= w_lo_fix;
          r_hi    <= w_hi_fix;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Status is decoded straight from the state register.
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.div_zero  = (r_state == S_DONE) & r_zero_flag;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance one cycle and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.wdata     = '0;
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [W-1:0] d);
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.wdata = d;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // Pulse start for one cycle; returns just after the accepting edge E0.
  task automatic start_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    tick();
    bus.start     = 1'b0;
  endtask

  // n counts edges from E0 inclusive (n=1 right after E0). Bounded wait.
  task automatic wait_done(inout int n, output bit ok);
    while (bus.done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ok = (bus.done === 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_divzero got %b want 0", bus.div_zero); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    n_checks++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.dbg_state); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_timing();
    start_div(1'b0, 32'd100, 32'd7);
    for (int n = 1; n <= 34; n++) begin
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timing_busy n=%0d got %b want 1", n, bus.busy); end
      n_checks++; if (bus.done !== (n == 34)) begin n_fail++; $display("FAIL timing_done n=%0d got %b want %b", n, bus.done, (n == 34)); end
      if (n < 34) tick();
    end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL udiv_lo got %h want %h", bus.lo, 32'd14); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL udiv_hi got %h want %h", bus.hi, 32'd2); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL udiv_divzero got %b want 0", bus.div_zero); end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timing_busy_fall got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL timing_done_width got %b want 0", bus.done); end
  endtask

  task automatic test_signed();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vs [4];
    logic [W-1:0] elo[4];
    logic [W-1:0] ehi[4];
    int n;
    bit ok;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        vs[0] = 1'b1; elo[0] = 32'hFFFFFFFD; ehi[0] = 32'hFFFFFFFF;
    va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE; vs[1] = 1'b1; elo[1] = 32'hFFFFFFFD; ehi[1] = 32'd1;
    va[2] = 32'hFFFFFFF9; vb[2] = 32'd2;        vs[2] = 1'b0; elo[2] = 32'h7FFFFFFC; ehi[2] = 32'd1;
    va[3] = 32'h80000000; vb[3] = 32'hFFFFFFFF; vs[3] = 1'b1; elo[3] = 32'h80000000; ehi[3] = 32'd0;
    for (int i = 0; i < 4; i++) begin
      start_div(vs[i], va[i], vb[i]);
      n = 1;
      wait_done(n, ok);
      n_checks++; if (!ok || n != 34) begin n_fail++; $display("FAIL sdiv%0d_latency got %0d want 34", i, n); end
      n_checks++; if (bus.lo !== elo[i]) begin n_fail++; $display("FAIL sdiv%0d_lo got %h want %h", i, bus.lo, elo[i]); end
      n_checks++; if (bus.hi !== ehi[i]) begin n_fail++; $display("FAIL sdiv%0d_hi got %h want %h", i, bus.hi, ehi[i]); end
      n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL sdiv%0d_divzero got %b want 0", i, bus.div_zero); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    mt_write(1'b1, 1'b0, 32'h1234);
    mt_write(1'b0, 1'b1, 32'h5678);
    n_checks++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL mthi got %h want 1234", bus.hi); end
    n_checks++; if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo got %h want 5678", bus.lo); end
    start_div(1'b0, 32'd55, 32'd0);
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL dz_done got %b want 1", bus.done); end
    n_checks++; if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", bus.div_zero); end
    n_checks++; if (bus.hi !== 32'h1234) begin n_fail++; $display("FAIL dz_hi got %h want 1234", bus.hi); end
    n_checks++; if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL dz_lo got %h want 5678", bus.lo); end
    tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dz_busy_after got %b want 0", bus.busy); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag_after got %b want 0", bus.div_zero); end
  endtask

  task automatic test_start_during_iter();
    int n;
    bit ok;
    start_div(1'b0, 32'd100, 32'd7);
    n = 1;
    repeat (4) begin tick(); n++; end
    // Competing start and an MTLO while busy: both must be dropped.
    bus.start = 1'b1; bus.is_signed = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    bus.lo_we = 1'b1; bus.wdata = 32'hBEEF;
    tick(); n++;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    n_checks++; if (bus.lo !== 32'h5678) begin n_fail++; $display("FAIL busy_mtlo got %h want 5678", bus.lo); end
    wait_done(n, ok);
    n_checks++; if (!ok || n != 34) begin n_fail++; $display("FAIL ignore_start_latency got %0d want 34", n); end
    n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL ignore_start_lo got %h want %h", bus.lo, 32'd14); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL ignore_start_hi got %h want %h", bus.hi, 32'd2); end
    repeat (3) tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_noqueue got %b want 0", bus.busy); end
  endtask

  task automatic test_hi_we_with_start();
    int n;
    bit ok;
    mt_write(1'b1, 1'b0, 32'hAAAA);
    n_checks++; if (bus.hi !== 32'hAAAA) begin n_fail++; $display("FAIL mthi2 got %h want aaaa", bus.hi); end
    bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
    start_div(1'b0, 32'd20, 32'd6);
    bus.hi_we = 1'b0;
    n_checks++; if (bus.hi !== 32'hAAAA) begin n_fail++; $display("FAIL start_wins_hi got %h want aaaa", bus.hi); end
    n = 1;
    wait_done(n, ok);
    n_checks++; if (!ok || n != 34) begin n_fail++; $display("FAIL start_wins_latency got %0d want 34", n); end
    n_checks++; if (bus.lo !== 32'd3) begin n_fail++; $display("FAIL start_wins_lo got %h want 3", bus.lo); end
    n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL start_wins_hi_res got %h want 2", bus.hi); end
    tick();
  endtask

  task automatic test_reset_mid_iter();
    int n;
    int pulses;
    bit ok;
    start_div(1'b0, 32'd1000, 32'd3);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi got %h want 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo got %h want 0", bus.lo); end
    n_checks++; if (bus.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_state got %0d want 0", bus.dbg_state); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) pulses++;
      tick();
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_nodone got %0d want 0", pulses); end
    start_div(1'b0, 32'd9, 32'd3);
    n = 1;
    wait_done(n, ok);
    n_checks++; if (!ok || n != 34) begin n_fail++; $display("FAIL post_rst_latency got %0d want 34", n); end
    n_checks++; if (bus.lo !== 32'd3) begin n_fail++; $display("FAIL post_rst_lo got %h want 3", bus.lo); end
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL post_rst_hi got %h want 0", bus.hi); end
    tick();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_unsigned_timing();
    test_signed();
    test_div_zero();
    test_start_during_iter();
    test_hi_we_with_start();
    test_reset_mid_iter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle division controller for the CPU's HI/LO unit. It accepts a divide command from the main control unit, checks for a zero divisor, runs a WIDTH-step restoring shift-subtract loop, and applies MIPS sign fix-up. It owns the HI/LO architectural registers, so the control FSM stalls on `busy` and consumes `done`/`div_zero` instead of relying on a single-cycle combinational divide.

## Interface

Parameters:
- WIDTH, 32: operand, quotient and remainder width. The iteration count equals WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  begin a divide; sampled only in IDLE
- is_signed  input  1  1 = DIV semantics, 0 = DIVU; sampled with start
- dividend  input  WIDTH  Data_a; sampled with start
- divisor  input  WIDTH  Data_b; sampled with start
- hi_we  input  1  MTHI write strobe
- lo_we  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse, high only in state DONE
- div_zero  output  1  exception flag, high only in DONE when the divisor was 0
- hi  output  WIDTH  remainder register
- lo  output  WIDTH  quotient register

## Operation

- States: IDLE, ITER, FIXUP, DONE. Internal registers: dvd_mag, dvs_mag, rem (WIDTH+1 bits), quo, count (clog2(WIDTH)+1 bits), q_neg, r_neg, zero_flag.
- IDLE with start=1:
  - Latch magnitudes. In signed mode, negate negative operands. 0x80000000 stays 0x80000000 as an unsigned magnitude.
  - q_neg = sign(a) XOR sign(b); r_neg = sign(a); signed mode only, else 0.
  - Divisor == 0: zero_flag=1, go to DONE.
  - Otherwise: rem=0, quo=dvd_mag, count=0, go to ITER.
- ITER, one bit per cycle:
  - Shift {rem, quo} left by 1.
  - If the shifted rem >= dvs_mag: rem -= dvs_mag and set quo[0]=1.
  - Increment count. After iteration WIDTH-1 (count == WIDTH-1 at the edge), go to FIXUP.
- FIXUP: lo = q_neg ? -quo : quo; hi = r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]; go to DONE.
- DONE: done=1; div_zero=zero_flag; go to IDLE. On a zero divisor, HI/LO keep their previous values.
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no exception. This falls out of the magnitude path.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.
- start while not IDLE (including DONE): ignored. No queuing, operands not re-sampled.
- hi_we/lo_we:
  - Written only when IDLE and start=0.
  - When start=1 in the same cycle, start wins and the writes are dropped.
  - Writes while busy are dropped.
  - hi_we and lo_we together write both registers with wdata.
- reset, any state including mid-ITER: next edge state=IDLE, hi=lo=0, busy=done=div_zero=0, internal registers cleared. The in-flight result is discarded.

## Timing

- E0 = edge sampling start in IDLE.
- Normal divide:
  - ITER occupies edges E1..EWIDTH.
  - FIXUP at EWIDTH+1 writes hi/lo.
  - done=1 in the cycle after EWIDTH+1, i.e. 34 cycles after the E0 edge for WIDTH=32.
  - hi/lo are valid in that same cycle.
- Zero divisor: done=div_zero=1 in the cycle after E0. Latency 1.
- busy rises in the cycle after E0 and falls the cycle after DONE.
- Back-to-back: a new start is accepted in the first IDLE cycle after DONE. Minimum issue interval is WIDTH+3 cycles.
- Outputs are all registered or decoded directly from state. No combinational path from inputs to outputs.

## Test plan

- Unsigned 100 / 7:
  - lo=14, hi=2.
  - done high exactly 34 cycles after the start edge, for exactly 1 cycle.
  - busy high for the 34 intervening cycles.
- Signed cases:
  - -7 / 2 (0xFFFFFFF9 / 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 7 / -2 → lo=0xFFFFFFFD, hi=1.
  - Unsigned 0xFFFFFFF9 / 2 → lo=0x7FFFFFFC, hi=1.
- Signed 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Divide by zero, with hi=0x1234 and lo=0x5678 preloaded via MTHI/MTLO:
  - 55 / 0 → cycle after start: done=1, div_zero=1.
  - hi=0x1234, lo=0x5678 unchanged.
- start pulsed again during ITER with different operands → ignored; original result delivered at the original cycle. Separately, hi_we with start in the same IDLE cycle → hi not written.
- reset asserted at iteration 10 of 1000 / 3 → next cycle busy=0, hi=lo=0, no done pulse. A fresh 9 / 3 then yields lo=3, hi=0 on normal timing.
